// File: rtl/sync_gate_former_if.sv
// sync_gate_former_if: strobe inputs and gate/bookkeeping outputs of sync_gate_former.
// master: sequencer side (drives strobes, err_clr); slave: sync_gate_former.
interface sync_gate_former_if #(
    parameter int CYC_W   = 16,
    parameter int PULSE_W = 8
);
    logic               tno;
    logic               tnc;
    logic               tni;
    logic               tki;
    logic               tnp;
    logic               tkp;
    logic               err_clr;
    logic               gate_tx;
    logic               gate_rx;
    logic               frame_start;
    logic [CYC_W-1:0]   cycle_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [15:0]        tx_len_us;
    logic [15:0]        rx_len_us;
    logic               err_seq;
    logic               err_overlap;
    logic               err_timeout;

    modport master (
        output tno, tnc, tni, tki, tnp, tkp, err_clr,
        input  gate_tx, gate_rx, frame_start, cycle_cnt, pulse_cnt,
        input  tx_len_us, rx_len_us, err_seq, err_overlap, err_timeout
    );

    modport slave (
        input  tno, tnc, tni, tki, tnp, tkp, err_clr,
        output gate_tx, gate_rx, frame_start, cycle_cnt, pulse_cnt,
        output tx_len_us, rx_len_us, err_seq, err_overlap, err_timeout
    );
endinterface

// File: rtl/sync_gate_former.sv
// sync_gate_former: turns sequencer strobes into tx/rx gates, counters, widths, errors.
// Ports: clk, rst_n (async low), tus (async 1 us tick), bus (slave modport).
module sync_gate_former #(
    parameter logic [15:0] MAX_GATE_US = 16'd1000,
    parameter int          CYC_W       = 16,
    parameter int          PULSE_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tus,
    sync_gate_former_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE, OBZ, CYC, TX, RX
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         stb_q;
    logic [2:0]         tus_q;
    logic [15:0]        wcnt_q, wcnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [PULSE_W-1:0] pul_q, pul_d;
    logic [15:0]        txl_q, txl_d;
    logic [15:0]        rxl_q, rxl_d;
    logic               fs_q, fs_d;
    logic [2:0]         err_q, err_d;

    logic [5:0]  stb;
    logic [5:0]  rise;
    logic        r_no, r_nc, r_ni, r_ki, r_np, r_kp;
    logic        tick;
    logic        gating;
    logic        closed;
    logic [15:0] wnext;
    logic        e_seq, e_ovl, e_tmo;

    assign stb  = {bus.tno, bus.tnc, bus.tni, bus.tki, bus.tnp, bus.tkp};
    assign rise = stb & ~stb_q;
    assign {r_no, r_nc, r_ni, r_ki, r_np, r_kp} = rise;

    // Rising edge of the synchronised us tick.
    assign tick   = tus_q[1] & ~tus_q[2];
    assign gating = (state_q == TX) || (state_q == RX);
    // Width including a tick landing in this clk.
    assign wnext  = wcnt_q + 16'(tick);
    assign closed = (r_ki && state_q == TX) || (r_kp && state_q == RX);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cyc_d   = cyc_q;
        pul_d   = pul_q;
        txl_d   = txl_q;
        rxl_d   = rxl_q;
        fs_d    = 1'b0;
        e_seq   = 1'b0;
        e_ovl   = 1'b0;
        e_tmo   = 1'b0;

        if (gating) begin
            wcnt_d = wnext;
        end

        if (r_no) begin
            state_d = OBZ;
            cyc_d   = '0;
            pul_d   = '0;
            fs_d    = 1'b1;
            e_seq   = gating;
        end else if (r_nc) begin
            if (state_q == IDLE) begin
                e_seq = 1'b1;
            end else begin
                e_seq   = gating;
                state_d = CYC;
                cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
                pul_d   = '0;
            end
        end else begin
            if (r_ki || r_kp) begin
                if (r_ki) begin
                    if (state_q == TX) begin
                        state_d = CYC;
                        txl_d   = wnext;
                    end else begin
                        e_seq = 1'b1;
                    end
                end
                if (r_kp) begin
                    if (state_q == RX) begin
                        state_d = CYC;
                        rxl_d   = wnext;
                    end else begin
                        e_seq = 1'b1;
                    end
                end
            end else begin
                unique case (state_q)
                    IDLE, OBZ: begin
                        e_seq = r_ni | r_np;
                    end
                    CYC: begin
                        if (r_ni) begin
                            state_d = TX;
                            wcnt_d  = '0;
                            pul_d   = (&pul_q) ? pul_q : pul_q + 1'b1;
                        end else if (r_np) begin
                            state_d = RX;
                            wcnt_d  = '0;
                        end
                    end
                    TX: begin
                        e_ovl = r_np;
                        e_seq = r_ni;
                    end
                    RX: begin
                        e_ovl = r_ni;
                        e_seq = r_np;
                    end
                    default: ;
                endcase
            end

            // An end strobe in the same clk beats the timeout.
            if (gating && !closed && wnext == MAX_GATE_US) begin
                state_d = CYC;
                e_tmo   = 1'b1;
                if (state_q == TX) begin
                    txl_d = MAX_GATE_US;
                end else begin
                    rxl_d = MAX_GATE_US;
                end
            end
        end

        // New errors win over a simultaneous clear.
        err_d = (err_q & {3{~bus.err_clr}}) | {e_tmo, e_ovl, e_seq};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stb_q   <= '0;
            tus_q   <= '0;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            pul_q   <= '0;
            txl_q   <= '0;
            rxl_q   <= '0;
            fs_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb;
            tus_q   <= {tus_q[1:0], tus};
            wcnt_q  <= wcnt_d;
            cyc_q   <= cyc_d;
            pul_q   <= pul_d;
            txl_q   <= txl_d;
            rxl_q   <= rxl_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign bus.gate_tx     = (state_q == TX);
    assign bus.gate_rx     = (state_q == RX);
    assign bus.frame_start = fs_q;
    assign bus.cycle_cnt   = cyc_q;
    assign bus.pulse_cnt   = pul_q;
    assign bus.tx_len_us   = txl_q;
    assign bus.rx_len_us   = rxl_q;
    assign bus.err_seq     = err_q[0];
    assign bus.err_overlap = err_q[1];
    assign bus.err_timeout = err_q[2];
endmodule

// File: tb/tb_sync_gate_former.sv
// tb_sync_gate_former: table-driven scoreboard bench for sync_gate_former.
// Two instances: default limit and MAX_GATE_US=4 for the timeout case.
module tb_sync_gate_former;
    typedef struct packed {
        logic        tx;
        logic        rx;
        logic        fs;
        logic [15:0] cyc;
        logic [7:0]  pul;
        logic [15:0] txl;
        logic [15:0] rxl;
        logic        es;
        logic        eo;
        logic        et;
    } out_t;

    typedef struct {
        string      name;
        int         ticks;
        logic [6:0] stb;
        out_t       exp;
    } vec_t;

    localparam logic [6:0] NO = 7'b1000000;
    localparam logic [6:0] NC = 7'b0100000;
    localparam logic [6:0] NI = 7'b0010000;
    localparam logic [6:0] KI = 7'b0001000;
    localparam logic [6:0] NP = 7'b0000100;
    localparam logic [6:0] KP = 7'b0000010;
    localparam logic [6:0] CL = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tus = 1'b0;

    int nvec = 0;
    int nfail = 0;
    out_t sb[$];
    vec_t tbl[$];

    sync_gate_former_if b ();
    sync_gate_former_if bt ();

    sync_gate_former dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tus   (tus),
        .bus   (b)
    );

    sync_gate_former #(.MAX_GATE_US(16'd4)) dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .tus   (tus),
        .bus   (bt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic out_t o(int tx, int rx, int fs, int cyc, int pul,
                               int txl, int rxl, int es, int eo, int et);
        out_t r;
        r.tx  = 1'(tx);
        r.rx  = 1'(rx);
        r.fs  = 1'(fs);
        r.cyc = 16'(cyc);
        r.pul = 8'(pul);
        r.txl = 16'(txl);
        r.rxl = 16'(rxl);
        r.es  = 1'(es);
        r.eo  = 1'(eo);
        r.et  = 1'(et);
        return r;
    endfunction

    function automatic out_t sample(bit alt);
        out_t r;
        if (alt) begin
            r = {bt.gate_tx, bt.gate_rx, bt.frame_start, bt.cycle_cnt,
                 bt.pulse_cnt, bt.tx_len_us, bt.rx_len_us,
                 bt.err_seq, bt.err_overlap, bt.err_timeout};
        end else begin
            r = {b.gate_tx, b.gate_rx, b.frame_start, b.cycle_cnt,
                 b.pulse_cnt, b.tx_len_us, b.rx_len_us,
                 b.err_seq, b.err_overlap, b.err_timeout};
        end
        return r;
    endfunction

    function automatic void add(string nm, int t, logic [6:0] s, out_t e);
        vec_t v;
        v.name  = nm;
        v.ticks = t;
        v.stb   = s;
        v.exp   = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, out_t got, out_t exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic drive(logic [6:0] s);
        {b.tno, b.tnc, b.tni, b.tki, b.tnp, b.tkp, b.err_clr} = s;
        {bt.tno, bt.tnc, bt.tni, bt.tki, bt.tnp, bt.tkp, bt.err_clr} = s;
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tus = 1'b1;
            repeat (3) @(negedge clk);
            tus = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic step(string nm, int t, logic [6:0] s, out_t e, bit alt);
        out_t want;
        tick_n(t);
        @(negedge clk);
        drive(s);
        sb.push_back(e);
        @(negedge clk);
        drive('0);
        want = sb.pop_front();
        chk(nm, sample(alt), want);
    endtask

    task automatic do_reset();
        drive('0);
        tus   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        add("t1_tno", 0, NO, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add("t1_tnc", 0, NC, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add("t1_tni", 0, NI, o(1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        add("t1_tki", 5, KI, o(0, 0, 0, 1, 1, 5, 0, 0, 0, 0));
        add("t2_tno", 0, NO, o(0, 0, 1, 0, 0, 5, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            int tl;
            int rl;
            tl = (k == 1) ? 5 : 2;
            rl = (k == 1) ? 0 : 12;
            add($sformatf("t2_tnc%0d", k), 0, NC, o(0, 0, 0, k, 0, tl, rl, 0, 0, 0));
            add($sformatf("t2_tni%0d", k), 0, NI, o(1, 0, 0, k, 1, tl, rl, 0, 0, 0));
            add($sformatf("t2_tki%0d", k), 2, KI, o(0, 0, 0, k, 1, 2, rl, 0, 0, 0));
            add($sformatf("t2_tnp%0d", k), 0, NP, o(0, 1, 0, k, 1, 2, rl, 0, 0, 0));
            add($sformatf("t2_tkp%0d", k), 12, KP, o(0, 0, 0, k, 1, 2, 12, 0, 0, 0));
        end
        add("t4_tni", 0, NI, o(1, 0, 0, 3, 2, 2, 12, 0, 0, 0));
        add("t4_ovl", 0, NP, o(1, 0, 0, 3, 2, 2, 12, 0, 1, 0));
        add("t4_clr", 0, CL, o(1, 0, 0, 3, 2, 2, 12, 0, 0, 0));
        add("t4_tki", 3, KI, o(0, 0, 0, 3, 2, 3, 12, 0, 0, 0));
        add("t5_nc_ni", 0, NC | NI, o(0, 0, 0, 4, 0, 3, 12, 0, 0, 0));
        add("t5_tnp", 0, NP, o(0, 1, 0, 4, 0, 3, 12, 0, 0, 0));
        add("t5_tno_rx", 4, NO, o(0, 0, 1, 0, 0, 3, 12, 1, 0, 0));
        add("clr_seq", 0, CL, o(0, 0, 0, 0, 0, 3, 12, 0, 0, 0));
        add("tni_obz", 0, NI, o(0, 0, 0, 0, 0, 3, 12, 1, 0, 0));
        add("clr_and_err", 0, CL | NI, o(0, 0, 0, 0, 0, 3, 12, 1, 0, 0));
        add("clr_again", 0, CL, o(0, 0, 0, 0, 0, 3, 12, 0, 0, 0));
        add("obz_tnc", 0, NC, o(0, 0, 0, 1, 0, 3, 12, 0, 0, 0));

        do_reset();
        chk("reset", sample(0), '0);
        chk("reset_to", sample(1), '0);

        step("t3_tno", 0, NO, o(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1);
        step("t3_tnc", 0, NC, o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1);
        step("t3_tni", 0, NI, o(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1);
        step("t3_tick3", 3, '0, o(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1);
        step("t3_tick4", 1, '0, o(0, 0, 0, 1, 1, 4, 0, 0, 0, 1), 1);
        step("t3_tick6", 2, '0, o(0, 0, 0, 1, 1, 4, 0, 0, 0, 1), 1);
        step("t3_tki", 0, KI, o(0, 0, 0, 1, 1, 4, 0, 1, 0, 1), 1);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].name, tbl[i].ticks, tbl[i].stb, tbl[i].exp, 0);
        end

        @(negedge clk);
        drive(NC);
        repeat (3) @(negedge clk);
        drive('0);
        @(negedge clk);
        chk("held_tnc", sample(0), o(0, 0, 0, 2, 0, 3, 12, 0, 0, 0));

        step("t6_tni", 0, NI, o(1, 0, 0, 2, 1, 3, 12, 0, 0, 0), 0);
        tick_n(300);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", sample(0), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_tki_idle", 0, KI, o(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
